// File: rtl/fpu_addsub_arbiter_if.sv
// Request/response/unit bundle for fpu_addsub_arbiter.
// The arbiter takes the slave view; requesters, consumer and the shared FP unit sit on the master side.
interface fpu_addsub_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_op;
   logic [32*NREQ-1:0]   req_x1;
   logic [32*NREQ-1:0]   req_x2;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_y;
   logic                 rsp_ovf;
   logic [31:0]          fu_x1;
   logic [31:0]          fu_x2;
   logic [31:0]          fu_y;
   logic                 fu_ovf;

   modport master (
      output req_valid, req_op, req_x1, req_x2, rsp_ready, fu_y, fu_ovf,
      input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf, fu_x1, fu_x2
   );

   modport slave (
      input  req_valid, req_op, req_x1, req_x2, rsp_ready, fu_y, fu_ovf,
      output req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf, fu_x1, fu_x2
   );
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin sharing of one combinational FP32 subtract unit across NREQ requesters, 2-stage in-order pipeline.
// Optional sticky overflow flag enabled by defining FPU_ARB_OVF_STICKY_EN.
module fpu_addsub_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   fpu_addsub_arbiter_if.slave   bus
`ifdef FPU_ARB_OVF_STICKY_EN
   ,
   output logic                  ovf_sticky,
   input  logic                  ovf_clr
`endif
);
   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   logic                 s1_valid_q;
   logic [IDW-1:0]       s1_id_q;
   logic [31:0]          s1_x1_q;
   logic [31:0]          s1_x2_q;
   logic                 s2_valid_q;
   logic [IDW-1:0]       s2_id_q;
   logic [31:0]          s2_y_q;
   logic                 s2_ovf_q;
   logic [IDW-1:0]       rr_ptr_q;
   logic [IDW-1:0]       rr_ptr_d;

   logic                 adv1;
   logic                 adv2;
   logic                 grant_any;
   logic [IDW-1:0]       grant_idx;
   logic [IDW:0]         cand_sum;
   logic [IDW-1:0]       cand;
   logic [NREQ-1:0]      ready;
   logic [31:0]          sel_x1;
   logic [31:0]          sel_x2;
   logic                 sel_op;
   logic [31:0]          x2_adj;

   // s2 may take s1 only when the consumer has room; s1 refills when empty or moving on
   assign adv2 = s1_valid_q & (~s2_valid_q | bus.rsp_ready);
   assign adv1 = ~s1_valid_q | adv2;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand_sum >= NREQ_W) begin
            cand_sum = cand_sum - NREQ_W;
         end
         cand = cand_sum[IDW-1:0];
         if (adv1 && !grant_any && bus.req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         ready[k] = grant_any && (grant_idx == IDW'(k));
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Add is realised as x1 - (-x2): only the sign bit of x2 is flipped
   assign sel_x1 = bus.req_x1[{grant_idx, 5'b0} +: 32];
   assign sel_x2 = bus.req_x2[{grant_idx, 5'b0} +: 32];
   assign sel_op = bus.req_op[grant_idx];
   assign x2_adj = sel_op ? sel_x2 : {~sel_x2[31], sel_x2[30:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s1_x1_q    <= '0;
         s1_x2_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= '0;
         s2_y_q     <= '0;
         s2_ovf_q   <= 1'b0;
         rr_ptr_q   <= '0;
      end else begin
         if (adv2) begin
            s2_valid_q <= 1'b1;
            s2_id_q    <= s1_id_q;
            s2_y_q     <= bus.fu_y;
            s2_ovf_q   <= bus.fu_ovf;
         end else if (s2_valid_q && bus.rsp_ready) begin
            s2_valid_q <= 1'b0;
         end
         if (adv1) begin
            s1_valid_q <= grant_any;
            if (grant_any) begin
               s1_id_q <= grant_idx;
               s1_x1_q <= sel_x1;
               s1_x2_q <= x2_adj;
            end
         end
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.fu_x1     = s1_x1_q;
   assign bus.fu_x2     = s1_x2_q;
   assign bus.rsp_valid = s2_valid_q;
   assign bus.rsp_id    = s2_id_q;
   assign bus.rsp_y     = s2_y_q;
   assign bus.rsp_ovf   = s2_ovf_q;

`ifdef FPU_ARB_OVF_STICKY_EN
   logic ovf_sticky_q;

   // A set in the same cycle as a clear takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_sticky_q <= 1'b0;
      end else if (s2_valid_q && bus.rsp_ready && s2_ovf_q) begin
         ovf_sticky_q <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky_q <= 1'b0;
      end
   end

   assign ovf_sticky = ovf_sticky_q;
`endif
endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed self-checking bench for fpu_addsub_arbiter; the shared FP unit is a small lookup model.
// Drives on the falling edge and samples 1ns later, away from the rising edge.
module tb_fpu_addsub_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   fails  = 0;

   fpu_addsub_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef FPU_ARB_OVF_STICKY_EN
   logic ovf_sticky;
   logic ovf_clr;
`endif

   fpu_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef FPU_ARB_OVF_STICKY_EN
      ,
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in for the subtract unit: exact results for the directed FP vectors, a scramble otherwise
   function automatic logic [32:0] unit_model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F800000 && b == 32'hC0000000) return {1'b0, 32'h40400000};
      if (a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'hBF800000};
      if (a == 32'h7F7FFFFF && b == 32'hFF7FFFFF) return {1'b1, 32'h7F800000};
      return {1'b0, a ^ {b[15:0], b[30:16], b[31]}};
   endfunction

   always_comb {bus.fu_ovf, bus.fu_y} = unit_model(bus.fu_x1, bus.fu_x2);

   function automatic logic [31:0] exp_y(input logic [31:0] a, input logic [31:0] b, input logic op);
      logic [32:0] r;
      r = unit_model(a, op ? b : {~b[31], b[30:0]});
      return r[31:0];
   endfunction

   task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
      bus.req_op[i]         = op;
      bus.req_x1[i*32 +: 32] = a;
      bus.req_x2[i*32 +: 32] = b;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_x1    = '0;
      bus.req_x2    = '0;
      bus.rsp_ready = 1'b0;
`ifdef FPU_ARB_OVF_STICKY_EN
      ovf_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
      checks++; if (bus.rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
      checks++; if (bus.rsp_y !== 32'h0) begin fails++; $display("FAIL reset_rsp_y: got %h expected 0", bus.rsp_y); end
      checks++; if (bus.rsp_ovf !== 1'b0) begin fails++; $display("FAIL reset_rsp_ovf: got %b expected 0", bus.rsp_ovf); end
      checks++; if (bus.fu_x1 !== 32'h0) begin fails++; $display("FAIL reset_fu_x1: got %h expected 0", bus.fu_x1); end
      checks++; if (bus.fu_x2 !== 32'h0) begin fails++; $display("FAIL reset_fu_x2: got %h expected 0", bus.fu_x2); end
`ifdef FPU_ARB_OVF_STICKY_EN
      checks++; if (ovf_sticky !== 1'b0) begin fails++; $display("FAIL reset_sticky: got %b expected 0", ovf_sticky); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_add();
      set_req(2, 1'b0, 32'h3F800000, 32'h40000000);
      bus.req_valid = 4'b0100;
      bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL add_ready: got %b expected 0100", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      checks++; if (bus.fu_x1 !== 32'h3F800000) begin fails++; $display("FAIL add_fu_x1: got %h expected 3f800000", bus.fu_x1); end
      checks++; if (bus.fu_x2 !== 32'hC0000000) begin fails++; $display("FAIL add_fu_x2: got %h expected c0000000", bus.fu_x2); end
      checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL add_early_valid: got %b expected 0", bus.rsp_valid); end
      @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL add_rsp_valid: got %b expected 1", bus.rsp_valid); end
      checks++; if (bus.rsp_y !== 32'h40400000) begin fails++; $display("FAIL add_rsp_y: got %h expected 40400000", bus.rsp_y); end
      checks++; if (bus.rsp_id !== 2'd2) begin fails++; $display("FAIL add_rsp_id: got %0d expected 2", bus.rsp_id); end
      checks++; if (bus.rsp_ovf !== 1'b0) begin fails++; $display("FAIL add_rsp_ovf: got %b expected 0", bus.rsp_ovf); end
      @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL add_drained: got %b expected 0", bus.rsp_valid); end
   endtask

   task automatic test_sub();
      set_req(0, 1'b1, 32'h3F800000, 32'h40000000);
      bus.req_valid = 4'b0001;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL sub_ready: got %b expected 0001", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      checks++; if (bus.fu_x2 !== 32'h40000000) begin fails++; $display("FAIL sub_fu_x2: got %h expected 40000000", bus.fu_x2); end
      @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL sub_rsp_valid: got %b expected 1", bus.rsp_valid); end
      checks++; if (bus.rsp_y !== 32'hBF800000) begin fails++; $display("FAIL sub_rsp_y: got %h expected bf800000", bus.rsp_y); end
      checks++; if (bus.rsp_id !== 2'd0) begin fails++; $display("FAIL sub_rsp_id: got %0d expected 0", bus.rsp_id); end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [31:0] x1 [NREQ];
      logic [31:0] x2 [NREQ];
      logic        op [NREQ];
      logic [3:0]  exp_rdy;
      int          g;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         x1[i] = 32'h10000000 * (i + 1) + i;
         x2[i] = 32'h00001111 * (i + 1) + 32'h80000000 * (i % 2);
         op[i] = (i % 2 == 1);
         set_req(i, op[i], x1[i], x2[i]);
      end
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) begin
         exp_rdy = 4'(1 << (k % 4));
         checks++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_rdy); end
         if (k >= 2) begin
            g = (k - 2) % 4;
            checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL rr_rsp_valid[%0d]: got %b expected 1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== IDW'(g)) begin fails++; $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", k, bus.rsp_id, g); end
            checks++; if (bus.rsp_y !== exp_y(x1[g], x2[g], op[g])) begin fails++; $display("FAIL rr_rsp_y[%0d]: got %h expected %h", k, bus.rsp_y, exp_y(x1[g], x2[g], op[g])); end
         end
         @(negedge clk);
         #1;
      end
      bus.req_valid = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rr_drained: got %b expected 0", bus.rsp_valid); end
   endtask

   task automatic test_backpressure();
      logic [31:0] ya, yb, yc;
      ya = exp_y(32'h11110001, 32'h22220001, 1'b1);
      yb = exp_y(32'h11110002, 32'h22220002, 1'b1);
      yc = exp_y(32'h11110003, 32'h22220003, 1'b1);
      bus.rsp_ready = 1'b0;
      set_req(1, 1'b1, 32'h11110001, 32'h22220001);
      bus.req_valid = 4'b0010;
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL bp_ready_a: got %b expected 0010", bus.req_ready); end
      @(negedge clk);
      set_req(1, 1'b1, 32'h11110002, 32'h22220002);
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL bp_ready_b: got %b expected 0010", bus.req_ready); end
      @(negedge clk);
      set_req(1, 1'b1, 32'h11110003, 32'h22220003);
      #1;
      for (int h = 0; h < 5; h++) begin
         checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL bp_full_ready[%0d]: got %b expected 0000", h, bus.req_ready); end
         checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== ya || bus.rsp_id !== 2'd1) begin
            fails++; $display("FAIL bp_hold[%0d]: got v=%b y=%h id=%0d expected v=1 y=%h id=1", h, bus.rsp_valid, bus.rsp_y, bus.rsp_id, ya);
         end
         @(negedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL bp_drain_accept: got %b expected 0010", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== yb) begin fails++; $display("FAIL bp_item_b: got v=%b y=%h expected v=1 y=%h", bus.rsp_valid, bus.rsp_y, yb); end
      @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== yc) begin fails++; $display("FAIL bp_item_c: got v=%b y=%h expected v=1 y=%h", bus.rsp_valid, bus.rsp_y, yc); end
      @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup: got %b expected 0", bus.rsp_valid); end
   endtask

   task automatic test_overflow();
      set_req(3, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF);
      bus.req_valid = 4'b1000;
      bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b1000) begin fails++; $display("FAIL ovf_ready: got %b expected 1000", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      checks++; if (bus.fu_x2 !== 32'hFF7FFFFF) begin fails++; $display("FAIL ovf_fu_x2: got %h expected ff7fffff", bus.fu_x2); end
      @(negedge clk);
      #1;
      checks++; if (bus.rsp_y !== 32'h7F800000) begin fails++; $display("FAIL ovf_rsp_y: got %h expected 7f800000", bus.rsp_y); end
      checks++; if (bus.rsp_ovf !== 1'b1) begin fails++; $display("FAIL ovf_rsp_ovf: got %b expected 1", bus.rsp_ovf); end
      @(negedge clk);
`ifdef FPU_ARB_OVF_STICKY_EN
      #1;
      checks++; if (ovf_sticky !== 1'b1) begin fails++; $display("FAIL sticky_set: got %b expected 1", ovf_sticky); end
      @(negedge clk);
      #1;
      checks++; if (ovf_sticky !== 1'b1) begin fails++; $display("FAIL sticky_hold: got %b expected 1", ovf_sticky); end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #1;
      checks++; if (ovf_sticky !== 1'b0) begin fails++; $display("FAIL sticky_clr: got %b expected 0", ovf_sticky); end
`endif
   endtask

   task automatic test_reset_midflight();
      bus.rsp_ready = 1'b0;
      set_req(2, 1'b1, 32'h01234567, 32'h89ABCDEF);
      bus.req_valid = 4'b0100;
      repeat (2) @(negedge clk);
      bus.req_valid = '0;
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_inflight: got %b expected 1", bus.rsp_valid); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_rsp_valid: got %b expected 0", bus.rsp_valid); end
      checks++; if (bus.fu_x1 !== 32'h0) begin fails++; $display("FAIL mid_fu_x1: got %h expected 0", bus.fu_x1); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_stale[%0d]: got %b expected 0", c, bus.rsp_valid); end
      end
      bus.req_valid = 4'b1111;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL mid_rr_ptr: got %b expected 0001", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      #1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_round_robin();
      test_backpressure();
      test_overflow();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
